// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 unified-memory slice.
//   MIPS_AW / MIPS_DW : default word-address and data widths (1024 x 32 memory)
//   arb_state_t       : arbiter sequencing states
//   owner_t           : which requester owns an in-flight read response
package mips32_pkg;

    localparam int MIPS_AW = 10;
    localparam int MIPS_DW = 32;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_STOPPED
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mips32_arb_prio.sv
// Two-way combinational priority pick between fetch and data.
// Data wins on contention unless the starvation override is raised,
// in which case fetch wins.
//   v_if     : fetch request, already qualified (flush/halt/state masked)
//   v_d      : data request, already qualified
//   force_if : fetch starvation limit reached
//   gnt_if   : fetch granted
//   gnt_d    : data granted
module mips32_arb_prio (
    input  logic v_if,
    input  logic v_d,
    input  logic force_if,
    output logic gnt_if,
    output logic gnt_d
);

    always_comb begin
        gnt_if = v_if && (!v_d || force_if);
        gnt_d  = v_d && !(v_if && force_if);
    end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Arbiter sharing the single-port unified I/D memory between the IF stage
// (fetch, read-only) and the MEM stage (LW/SW). One access per cycle, data
// first, with a bounded anti-starvation override for fetch. Read data comes
// back one cycle after the accept and is steered to the owning requester.
//   clk, rst_n        : clock, asynchronous active-low reset
//   if_req_*          : fetch request / handshake
//   if_rsp_*          : fetch response (killed by flush)
//   d_req_*           : load/store request / handshake
//   d_rsp_*           : load data or store completion (data 0)
//   flush             : taken branch; masks fetch and kills pending fetch data
//   halt, halted      : stop granting, drain, report stopped
//   mem_*             : single-port synchronous memory interface
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int AW         = MIPS_AW,
    parameter int DW         = MIPS_DW,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req_valid,
    input  logic [AW-1:0] if_req_addr,
    output logic          if_req_ready,
    output logic          if_rsp_valid,
    output logic [DW-1:0] if_rsp_data,
    input  logic          d_req_valid,
    input  logic          d_req_we,
    input  logic [AW-1:0] d_req_addr,
    input  logic [DW-1:0] d_req_wdata,
    output logic          d_req_ready,
    output logic          d_rsp_valid,
    output logic [DW-1:0] d_rsp_data,
    input  logic          flush,
    input  logic          halt,
    output logic          halted,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    logic          rd_pend;
    owner_t        rd_owner;
    logic          wr_ack;

    logic arb_on;
    logic v_if;
    logic v_d;
    logic starved;
    logic gnt_if;
    logic gnt_d;
    logic rd_pend_nxt;
    logic wr_ack_nxt;
    logic pend_nxt;
    logic if_pend;
    logic d_rd;

    // Halt gates grants in the very cycle it is raised.
    assign arb_on  = (state == ST_RUN) && !halt;
    assign v_if    = arb_on && if_req_valid && !flush;
    assign v_d     = arb_on && d_req_valid;
    assign starved = (starve_cnt == SW'(STARVE_MAX));

    mips32_arb_prio u_prio (
        .v_if     (v_if),
        .v_d      (v_d),
        .force_if (starved),
        .gnt_if   (gnt_if),
        .gnt_d    (gnt_d)
    );

    always_comb begin
        if_req_ready = gnt_if;
        d_req_ready  = gnt_d;
        mem_en       = gnt_if || gnt_d;
        mem_we       = gnt_d && d_req_we;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (gnt_d) begin
            mem_addr = d_req_addr;
            if (d_req_we)
                mem_wdata = d_req_wdata;
        end else if (gnt_if) begin
            mem_addr = if_req_addr;
        end
    end

    assign rd_pend_nxt = gnt_if || (gnt_d && !d_req_we);
    assign wr_ack_nxt  = gnt_d && d_req_we;
    assign pend_nxt    = rd_pend_nxt || wr_ack_nxt;

    // A pending fetch is simply never reported under flush; rd_pend is
    // rewritten every edge, so the killed response is gone one cycle later.
    always_comb begin
        if_pend      = rd_pend && (rd_owner == OWN_IF);
        d_rd         = rd_pend && (rd_owner == OWN_D);
        if_rsp_valid = if_pend && !flush;
        if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
        d_rsp_valid  = d_rd || wr_ack;
        d_rsp_data   = d_rd ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            halted     <= 1'b0;
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= OWN_IF;
            wr_ack     <= 1'b0;
        end else begin
            rd_pend  <= rd_pend_nxt;
            rd_owner <= gnt_if ? OWN_IF : OWN_D;
            wr_ack   <= wr_ack_nxt;

            if (!if_req_valid)
                starve_cnt <= '0;
            else if (flush)
                starve_cnt <= starve_cnt;
            else if (gnt_if)
                starve_cnt <= '0;
            else if (gnt_d && !starved)
                starve_cnt <= starve_cnt + SW'(1);

            // Drain completion looks at what remains outstanding after this
            // edge: responses due in the halt cycle finish at that same edge,
            // so STOPPED is reached one cycle after halt.
            case (state)
                ST_RUN: begin
                    if (halt) begin
                        state  <= pend_nxt ? ST_DRAIN : ST_STOPPED;
                        halted <= !pend_nxt;
                    end
                end
                ST_DRAIN: begin
                    if (!pend_nxt) begin
                        state  <= ST_STOPPED;
                        halted <= 1'b1;
                    end
                end
                ST_STOPPED: begin
                    state  <= ST_STOPPED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= ST_STOPPED;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
module tb_mips32_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_req_ready;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rsp_data;
    logic          d_req_valid;
    logic          d_req_we;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;
    logic          flush;
    logic          halt;
    logic          halted;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int passed;
    int total;

    mips32_mem_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_we     (d_req_we),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_req_ready  (d_req_ready),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .flush        (flush),
        .halt         (halt),
        .halted       (halted),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory: write at the accept edge, read data next cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                mem[mem_addr] <= mem_wdata;
            else
                mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        if_req_addr  = '0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
        d_req_addr   = '0;
        d_req_wdata  = '0;
        flush        = 1'b0;
        halt         = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        total++;
        if ({if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid, halted, mem_en, mem_we} !== 7'b0)
            $display("FAIL reset_flags got=%b want=0000000",
                     {if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid, halted, mem_en, mem_we});
        else passed++;
        total++;
        if ({if_rsp_data, d_rsp_data, mem_addr, mem_wdata} !== '0)
            $display("FAIL reset_buses if_rsp=%h d_rsp=%h addr=%h wdata=%h want all 0",
                     if_rsp_data, d_rsp_data, mem_addr, mem_wdata);
        else passed++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        if_req_valid = 1'b1;
        if_req_addr  = 10'd3;
        @(negedge clk);
        total++;
        if (if_req_ready !== 1'b1 || halted !== 1'b0)
            $display("FAIL reset_release_ready ready=%b halted=%b want 1/0", if_req_ready, halted);
        else passed++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_fetch_read();
        if_req_valid = 1'b1;
        if_req_addr  = 10'd5;
        @(negedge clk);
        total++;
        if (if_req_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd5)
            $display("FAIL fetch_accept ready=%b en=%b we=%b addr=%0d want 1/1/0/5",
                     if_req_ready, mem_en, mem_we, mem_addr);
        else passed++;
        tick();
        idle_inputs();
        @(negedge clk);
        total++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'hDEADBEEF)
            $display("FAIL fetch_rsp valid=%b data=%h want 1/deadbeef", if_rsp_valid, if_rsp_data);
        else passed++;
        total++;
        if (d_rsp_valid !== 1'b0 || d_rsp_data !== 32'h0)
            $display("FAIL fetch_rsp_d_quiet valid=%b data=%h want 0/0", d_rsp_valid, d_rsp_data);
        else passed++;
        tick();
        @(negedge clk);
        total++;
        if (if_rsp_valid !== 1'b0)
            $display("FAIL fetch_rsp_single valid=%b want 0", if_rsp_valid);
        else passed++;
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] want;
        if_req_valid = 1'b1;
        if_req_addr  = 10'd5;
        d_req_valid  = 1'b1;
        d_req_we     = 1'b0;
        d_req_addr   = 10'd6;
        for (int i = 0; i < 8; i++) begin
            // {if_ready, d_ready}: D, D, D, I repeating
            want = ((i % 4) == 3) ? 2'b10 : 2'b01;
            @(negedge clk);
            total++;
            if ({if_req_ready, d_req_ready} !== want)
                $display("FAIL contention_cyc%0d got if/d=%b want=%b", i, {if_req_ready, d_req_ready}, want);
            else passed++;
            if (i == 4) begin
                total++;
                if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'hDEADBEEF || d_rsp_valid !== 1'b0)
                    $display("FAIL contention_if_rsp ifv=%b data=%h dv=%b want 1/deadbeef/0",
                             if_rsp_valid, if_rsp_data, d_rsp_valid);
                else passed++;
            end
            if (i == 5) begin
                total++;
                if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h00000066 || if_rsp_valid !== 1'b0)
                    $display("FAIL contention_d_rsp dv=%b data=%h ifv=%b want 1/00000066/0",
                             d_rsp_valid, d_rsp_data, if_rsp_valid);
                else passed++;
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_store_load();
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = 10'd7;
        d_req_wdata = 32'h1234;
        @(negedge clk);
        total++;
        if (d_req_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd7 || mem_wdata !== 32'h1234)
            $display("FAIL store_accept ready=%b we=%b addr=%0d wdata=%h want 1/1/7/1234",
                     d_req_ready, mem_we, mem_addr, mem_wdata);
        else passed++;
        tick();
        idle_inputs();
        @(negedge clk);
        total++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0)
            $display("FAIL store_ack valid=%b data=%h want 1/0", d_rsp_valid, d_rsp_data);
        else passed++;
        tick();
        d_req_valid = 1'b1;
        d_req_addr  = 10'd7;
        @(negedge clk);
        total++;
        if (d_req_ready !== 1'b1 || mem_we !== 1'b0)
            $display("FAIL load_accept ready=%b we=%b want 1/0", d_req_ready, mem_we);
        else passed++;
        tick();
        idle_inputs();
        @(negedge clk);
        total++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h1234 || if_rsp_valid !== 1'b0)
            $display("FAIL load_rsp valid=%b data=%h ifv=%b want 1/1234/0", d_rsp_valid, d_rsp_data, if_rsp_valid);
        else passed++;
        tick();
    endtask

    task automatic test_flush();
        if_req_valid = 1'b1;
        if_req_addr  = 10'd10;
        tick();
        flush       = 1'b1;
        d_req_valid = 1'b1;
        d_req_addr  = 10'd9;
        @(negedge clk);
        total++;
        if (if_rsp_valid !== 1'b0 || if_rsp_data !== 32'h0)
            $display("FAIL flush_kill valid=%b data=%h want 0/0", if_rsp_valid, if_rsp_data);
        else passed++;
        total++;
        if (if_req_ready !== 1'b0 || d_req_ready !== 1'b1)
            $display("FAIL flush_mask if_ready=%b d_ready=%b want 0/1", if_req_ready, d_req_ready);
        else passed++;
        tick();
        idle_inputs();
        @(negedge clk);
        total++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'hCAFEF00D || if_rsp_valid !== 1'b0)
            $display("FAIL flush_d_rsp dv=%b data=%h ifv=%b want 1/cafef00d/0", d_rsp_valid, d_rsp_data, if_rsp_valid);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid_access();
        if_req_valid = 1'b1;
        if_req_addr  = 10'd5;
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        total++;
        if (if_rsp_valid !== 1'b0)
            $display("FAIL reset_mid_in valid=%b want 0", if_rsp_valid);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0)
            $display("FAIL reset_mid_after ifv=%b dv=%b want 0/0", if_rsp_valid, d_rsp_valid);
        else passed++;
        tick();
    endtask

    task automatic test_halt();
        d_req_valid = 1'b1;
        d_req_addr  = 10'd7;
        tick();
        halt         = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 10'd5;
        d_req_addr   = 10'd9;
        @(negedge clk);
        total++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h1234)
            $display("FAIL halt_drain_rsp valid=%b data=%h want 1/1234", d_rsp_valid, d_rsp_data);
        else passed++;
        total++;
        if (if_req_ready !== 1'b0 || d_req_ready !== 1'b0 || mem_en !== 1'b0 || halted !== 1'b0)
            $display("FAIL halt_same_cycle ifr=%b dr=%b en=%b halted=%b want 0/0/0/0",
                     if_req_ready, d_req_ready, mem_en, halted);
        else passed++;
        tick();
        halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (halted !== 1'b1 || if_req_ready !== 1'b0 || d_req_ready !== 1'b0 || mem_en !== 1'b0)
                $display("FAIL halt_stopped_cyc%0d halted=%b ifr=%b dr=%b en=%b want 1/0/0/0",
                         i, halted, if_req_ready, d_req_ready, mem_en);
            else passed++;
            tick();
        end
        idle_inputs();
        rst_n = 1'b0;
        #2;
        total++;
        if (halted !== 1'b0)
            $display("FAIL halt_reset halted=%b want 0", halted);
        else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        d_req_valid = 1'b1;
        d_req_addr  = 10'd7;
        @(negedge clk);
        total++;
        if (halted !== 1'b0 || d_req_ready !== 1'b1)
            $display("FAIL halt_rerun halted=%b ready=%b want 0/1", halted, d_req_ready);
        else passed++;
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        mem_rdata = '0;
        for (int unsigned a = 0; a < (1 << AW); a++)
            mem[a] = '0;
        mem[5]  = 32'hDEADBEEF;
        mem[6]  = 32'h00000066;
        mem[9]  = 32'hCAFEF00D;
        mem[10] = 32'hABCD0123;
        rst_n   = 1'b0;
        idle_inputs();

        test_reset();
        test_fetch_read();
        test_contention();
        test_store_load();
        test_flush();
        test_reset_mid_access();
        test_halt();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule
